// File: rtl/fpu_rs_pkg.sv
// Shared types for the FP reservation station: result-bus format, station entry, wakeup helpers.
package fpu_rs_pkg;

    localparam int ROB_WIDTH = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    // Op mode is kept in a separately parameterised array in the station.
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        cdb_t [1:0]           opd;
    } fpu_rs_entry_t;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } fpu_rs_result_t;

    function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] t);
        return bus.valid && (bus.tag == t);
    endfunction

    // Returns the operand with the broadcast applied when it was still waiting on that tag.
    // A valid operand (e.g. a register-file read) always has priority over the bus.
    function automatic cdb_t opd_wake(input cdb_t opd, input cdb_t bus);
        cdb_t w;
        w = opd;
        if (!opd.valid && tag_match(bus, opd.tag)) begin
            w.valid = 1'b1;
            w.data  = bus.data;
        end
        return w;
    endfunction

endpackage

// File: rtl/fpu_rs_result_fifo.sv
// Result buffer between the fixed-latency core and the result-bus arbiter.
// DEPTH need not be a power of two; pointers wrap explicitly.
module fpu_rs_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fpu_rs.sv
// Reservation station and result tracker for a fixed-latency, non-stallable FP core.
// Define FPU_RS_BYPASS_EN to let an entry dispatch in the same cycle its last operand is broadcast.
module fpu_rs
    import fpu_rs_pkg::*;
#(
    parameter int N_ENTRY    = 4,
    parameter int LATENCY    = 3,
    parameter int OUT_DEPTH  = 4,
    parameter int MODE_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ROB_WIDTH-1:0]  issue_tag,
    input  logic [MODE_WIDTH-1:0] issue_mode,
    input  cdb_t [1:0]            fpr_read,
    input  cdb_t                  fpr_cdb,
    output logic [31:0]           core_a,
    output logic [31:0]           core_b,
    output logic [MODE_WIDTH-1:0] core_mode,
    input  logic [31:0]           core_result,
    output logic                  cdb_req_valid,
    input  logic                  cdb_req_ready,
    output logic [ROB_WIDTH-1:0]  tag,
    output logic [31:0]           result
);

    localparam int IDX_W = $clog2(N_ENTRY);
    localparam int CNT_W = $clog2(N_ENTRY + 1);
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int CR_W  = $clog2(OUT_DEPTH + LATENCY + 1) + 1;
    localparam int RES_W = $bits(fpu_rs_result_t);

    fpu_rs_entry_t         entry_q   [N_ENTRY];
    fpu_rs_entry_t         entry_d   [N_ENTRY];
    fpu_rs_entry_t         woken     [N_ENTRY];
    fpu_rs_entry_t         shifted   [N_ENTRY];
    logic [MODE_WIDTH-1:0] mode_q    [N_ENTRY];
    logic [MODE_WIDTH-1:0] mode_d    [N_ENTRY];
    logic [MODE_WIDTH-1:0] mode_sh   [N_ENTRY];
    fpu_rs_entry_t         new_entry;

    logic [LATENCY-1:0]    pipe_valid_q, pipe_valid_d;
    logic [ROB_WIDTH-1:0]  pipe_tag_q [LATENCY];
    logic [ROB_WIDTH-1:0]  pipe_tag_d [LATENCY];

    logic [N_ENTRY-1:0]    ready;
    logic [IDX_W-1:0]      sel;
    logic [CR_W-1:0]       inflight;
    logic [OCC_W-1:0]      occ;
    logic [CNT_W-1:0]      n_valid;
    logic [CNT_W-1:0]      land;
    logic                  credit_ok;
    logic                  dispatch;
    logic                  issue_fire;
    cdb_t                  opd_a, opd_b;
    fpu_rs_result_t        fifo_in, fifo_head;

    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) begin
`ifdef FPU_RS_BYPASS_EN
            ready[i] = entry_q[i].valid
                    && (entry_q[i].opd[0].valid || tag_match(fpr_cdb, entry_q[i].opd[0].tag))
                    && (entry_q[i].opd[1].valid || tag_match(fpr_cdb, entry_q[i].opd[1].tag));
`else
            ready[i] = entry_q[i].valid && entry_q[i].opd[0].valid && entry_q[i].opd[1].valid;
`endif
        end
    end

    // Entries are kept compacted, so the lowest ready index is the oldest ready op.
    always_comb begin
        sel = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    // Every op in flight already owns a buffer slot, so the core can never overrun the buffer.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < LATENCY; s++) begin
            inflight = inflight + CR_W'(pipe_valid_q[s]);
        end
    end

    assign credit_ok   = (inflight + CR_W'(occ)) < CR_W'(OUT_DEPTH);
    assign dispatch    = (|ready) && credit_ok;
    assign issue_ready = !entry_q[N_ENTRY-1].valid || dispatch;
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        opd_a = entry_q[sel].opd[0];
        opd_b = entry_q[sel].opd[1];
`ifdef FPU_RS_BYPASS_EN
        opd_a = opd_wake(opd_a, fpr_cdb);
        opd_b = opd_wake(opd_b, fpr_cdb);
`endif
        core_a    = opd_a.data;
        core_b    = opd_b.data;
        core_mode = mode_q[sel];
    end

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            woken[i]        = entry_q[i];
            woken[i].opd[0] = opd_wake(entry_q[i].opd[0], fpr_cdb);
            woken[i].opd[1] = opd_wake(entry_q[i].opd[1], fpr_cdb);
            n_valid         = n_valid + CNT_W'(entry_q[i].valid);
        end

        for (int i = 0; i < N_ENTRY - 1; i++) begin
            shifted[i] = woken[i+1];
            mode_sh[i] = mode_q[i+1];
        end
        shifted[N_ENTRY-1] = '0;
        mode_sh[N_ENTRY-1] = mode_q[N_ENTRY-1];

        new_entry.valid  = 1'b1;
        new_entry.tag    = issue_tag;
        new_entry.opd[0] = opd_wake(fpr_read[0], fpr_cdb);
        new_entry.opd[1] = opd_wake(fpr_read[1], fpr_cdb);

        // Lowest free slot after this cycle's compaction.
        land = n_valid - CNT_W'(dispatch);

        for (int i = 0; i < N_ENTRY; i++) begin
            if (dispatch && (int'(sel) <= i)) begin
                entry_d[i] = shifted[i];
                mode_d[i]  = mode_sh[i];
            end else begin
                entry_d[i] = woken[i];
                mode_d[i]  = mode_q[i];
            end
            if (issue_fire && (land == CNT_W'(i))) begin
                entry_d[i] = new_entry;
                mode_d[i]  = issue_mode;
            end
        end
    end

    always_comb begin
        pipe_valid_d[0] = dispatch;
        pipe_tag_d[0]   = entry_q[sel].tag;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_valid_d[s] = pipe_valid_q[s-1];
            pipe_tag_d[s]   = pipe_tag_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                entry_q[i] <= '0;
            end
            pipe_valid_q <= '0;
        end else begin
            entry_q      <= entry_d;
            pipe_valid_q <= pipe_valid_d;
        end
        mode_q     <= mode_d;
        pipe_tag_q <= pipe_tag_d;
    end

    assign fifo_in.tag  = pipe_tag_q[LATENCY-1];
    assign fifo_in.data = core_result;

    fpu_rs_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (RES_W)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid_q[LATENCY-1]),
        .push_data (fifo_in),
        .pop       (cdb_req_valid && cdb_req_ready),
        .head_data (fifo_head),
        .count     (occ)
    );

    assign cdb_req_valid = (occ != '0);
    assign tag           = fifo_head.tag;
    assign result        = fifo_head.data;

endmodule
